sr_latch_bank_ctrl: RTL



---
 rtl/sr_ctrl_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 18 +
 rtl/sr_latch_bank_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/sr_ctrl_pkg.sv
// sr_ctrl_pkg: FSM states and {s,r} command encodings shared by the SR latch bank controller
package sr_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, RELEASE, DONE} state_t;
  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_RST = 2'b01;
  localparam logic [1:0] CMD_SET = 2'b10;
  localparam logic [1:0] CMD_ILL = 2'b11;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant; the lowest requester at or after ptr wins
// ports: req (request vector), ptr (priority start index), gnt (one-hot grant, 0 when no req)
module rr_arbiter #(
  parameter int N = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);
  logic [N-1:0] low, first;
  logic [2*N-1:0] rot;
  // rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back
  assign low = N'({req, req} >> ptr);
  assign first = low & (~low + N'(1));
  assign rot = {{N{1'b0}}, first} << ptr;
  assign gnt = rot[N-1:0] | rot[2*N-1:N];
endmodule

// File: rtl/sr_latch_bank_ctrl.sv
// sr_latch_bank_ctrl: shares one gated SR latch bank between requesters (setup, gate pulse, release, check)
// ports: clk/rst (sync, active-high); req/cmd/idx per requester in; ack/err/busy status out;
//        latch_s/latch_r/latch_control drive the bank; latch_q is the bank readback
module sr_latch_bank_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_LATCH = 8,
  parameter int IDX_W = 3,
  parameter int PULSE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [2*NUM_REQ-1:0]     cmd,
  input  logic [IDX_W*NUM_REQ-1:0] idx,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     err,
  output logic                     busy,
  output logic [NUM_LATCH-1:0]     latch_s,
  output logic [NUM_LATCH-1:0]     latch_r,
  output logic                     latch_control,
  input  logic [NUM_LATCH-1:0]     latch_q
);
  localparam int PTR_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = PULSE_CYCLES > 1 ? $clog2(PULSE_CYCLES) : 1;
  state_t state, state_n;
  logic [PTR_W-1:0] ptr, gsel, gidx, cur_g;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0] cmd_q, cur_cmd;
  logic [IDX_W-1:0] idx_q, cur_idx;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NUM_LATCH-1:0] sel;
  logic bad, q_bit, drive, chk_err;
  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (.req(req), .ptr(ptr), .gnt(gnt));
  always_comb begin
    gsel = '0;
    for (int i = 0; i < NUM_REQ; i++) gsel = gnt[i] ? PTR_W'(i) : gsel;
  end
  // in IDLE look at the live grantee, afterwards at the captured operation
  assign cur_g = state == IDLE ? gsel : gidx;
  assign cur_cmd = state == IDLE ? cmd[2*gsel +: 2] : cmd_q;
  assign cur_idx = state == IDLE ? idx[IDX_W*gsel +: IDX_W] : idx_q;
  assign bad = cur_cmd == CMD_ILL || 32'(cur_idx) >= NUM_LATCH;
  assign sel = NUM_LATCH'(1) << cur_idx;
  assign q_bit = |(latch_q & sel);
  assign chk_err = (cmd_q == CMD_SET && !q_bit) || (cmd_q == CMD_RST && q_bit);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: state_n = !(|req) ? IDLE : bad ? DONE : SETUP;
      SETUP: begin
        state_n = PULSE;
        cnt_n = CNT_W'(PULSE_CYCLES - 1);
      end
      PULSE: begin
        state_n = cnt == '0 ? RELEASE : PULSE;
        cnt_n = cnt - 1'b1;
      end
      RELEASE: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from the state being entered, so they line up with the state
  assign drive = state_n inside {SETUP, PULSE, RELEASE};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      gidx <= '0;
      cmd_q <= CMD_NOP;
      idx_q <= '0;
      ack <= '0;
      err <= 1'b0;
      busy <= 1'b0;
      latch_s <= '0;
      latch_r <= '0;
      latch_control <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      gidx <= cur_g;
      cmd_q <= cur_cmd;
      idx_q <= cur_idx;
      ptr <= state == DONE ? (gidx == PTR_W'(NUM_REQ - 1) ? '0 : gidx + 1'b1) : ptr;
      ack <= state_n == DONE ? NUM_REQ'(1) << cur_g : '0;
      err <= state_n == DONE && (state == IDLE || chk_err);
      busy <= state_n != IDLE;
      latch_s <= drive && cur_cmd == CMD_SET ? sel : '0;
      latch_r <= drive && cur_cmd == CMD_RST ? sel : '0;
      latch_control <= state_n == PULSE;
    end
  end
endmodule
